// File: rtl/mul_share_arb.sv
// Round-robin sequencer sharing one 4x4 array multiplier among NREQ requesters.
// Build option MUL_SHARE_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead of round robin.
module mul_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_p,
  output logic              busy
);

  localparam int NPAD = 1 << IDW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  state_t            state_r, state_nx_s;
  logic [3:0]        a_r, b_r;
  logic [IDW-1:0]    id_r;
  logic              rsp_valid_r, busy_r;
  logic [7:0]        rsp_p_r;
  logic [IDW-1:0]    rsp_id_r;
  logic [NPAD-1:0]   valid_pad_s;
  logic [4*NPAD-1:0] a_pad_s, b_pad_s;
  logic [IDW-1:0]    grant_s;
  logic              found_s, accept_s;

  // Shift-and-add array multiplier: one partial product per multiplier bit.
  function automatic logic [7:0] mul4x4(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] acc;
    acc = 8'd0;
    for (int j = 0; j < 4; j++) begin
      if (b[j]) acc = acc + ({4'd0, a} << j);
      else      acc = acc;
    end
    return acc;
  endfunction

  // Pad request vectors to 2^IDW entries so an IDW-bit index addresses them exactly.
  always_comb begin
    valid_pad_s = '0;
    a_pad_s     = '0;
    b_pad_s     = '0;
    valid_pad_s[NREQ-1:0]   = req_valid;
    a_pad_s[4*NREQ-1:0]     = req_a;
    b_pad_s[4*NREQ-1:0]     = req_b;
  end

`ifdef MUL_SHARE_FIXED_PRIO_EN
  // Fixed priority: scanning downward leaves the lowest active index as winner.
  always_comb begin
    grant_s = {IDW{1'b0}};
    found_s = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (valid_pad_s[IDW'(k)]) begin
        found_s = 1'b1;
        grant_s = IDW'(k);
      end else begin
        found_s = found_s;
      end
    end
  end
`else
  logic [IDW-1:0] last_r;
  logic [IDW-1:0] cand_s;

  // Round-robin search starting just after the most recent grant.
  always_comb begin
    grant_s = {IDW{1'b0}};
    found_s = 1'b0;
    cand_s  = {IDW{1'b0}};
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IDW'((int'(last_r) + k) % NREQ);
      if (!found_s && valid_pad_s[cand_s]) begin
        found_s = 1'b1;
        grant_s = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer moves only when a request is actually accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_r <= IDW'(NREQ - 1);
    else if (accept_s) last_r <= grant_s;
    else               last_r <= last_r;
  end
`endif

  assign accept_s = rst_n && (state_r == ST_IDLE) && found_s;

  // One-hot accept strobe and next-state decode.
  always_comb begin
    req_ready  = {NREQ{1'b0}};
    state_nx_s = state_r;
    if (accept_s) req_ready = {{(NREQ-1){1'b0}}, 1'b1} << grant_s;
    else          req_ready = {NREQ{1'b0}};
    case (state_r)
      ST_IDLE: state_nx_s = accept_s ? ST_MUL : ST_IDLE;
      ST_MUL:  state_nx_s = ST_RSP;
      ST_RSP:  state_nx_s = rsp_ready ? ST_IDLE : ST_RSP;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, operand capture and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      a_r         <= 4'd0;
      b_r         <= 4'd0;
      id_r        <= {IDW{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_p_r     <= 8'd0;
      rsp_id_r    <= {IDW{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != ST_IDLE);
      if (accept_s) begin
        a_r  <= a_pad_s[{grant_s, 2'b00} +: 4];
        b_r  <= b_pad_s[{grant_s, 2'b00} +: 4];
        id_r <= grant_s;
      end else begin
        a_r  <= a_r;
        b_r  <= b_r;
        id_r <= id_r;
      end
      if (state_r == ST_MUL) begin
        rsp_p_r     <= mul4x4(a_r, b_r);
        rsp_id_r    <= id_r;
        rsp_valid_r <= 1'b1;
      end else if (state_r == ST_RSP && rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end else begin
        rsp_valid_r <= rsp_valid_r;
      end
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_p     = rsp_p_r;
  assign rsp_id    = rsp_id_r;
  assign busy      = busy_r;

endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Round-robin arbiter and sequencer that shares one 4x4 unsigned array-multiplier datapath among `NREQ` requesters. The block accepts one operand pair at a time over per-requester valid/ready channels and registers operands and product. It returns the 8-bit product with the winner's ID on a single shared response channel. It sits between the requesting engines and the multiplier, so only one multiplier instance is needed per cluster.

## Interface
- `NREQ`, 4: number of requesters, legal range 2..8.
- `IDW`, 3: width of the requester ID; must satisfy 2^IDW >= NREQ.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `req_valid` in NREQ: bit i set means requester i presents an operand pair.
- `req_a` in 4*NREQ: multiplicand of requester i in bits [4i+3:4i].
- `req_b` in 4*NREQ: multiplier of requester i in bits [4i+3:4i].
- `req_ready` out NREQ: one-hot accept strobe; bit i set means requester i's pair is taken this cycle.
- `rsp_valid` out 1: product available.
- `rsp_ready` in 1: response consumer accepts.
- `rsp_id` out IDW: index of the requester that owns `rsp_p`.
- `rsp_p` out 8: unsigned product A*B.
- `busy` out 1: high in MUL and RSP.

## Operation
- FSM states: IDLE, MUL, RSP. Reset state is IDLE.
- IDLE:
  - If any `req_valid` is set, select grant g.
  - Drive `req_ready[g]`=1, combinationally from the state and `req_valid`.
  - Latch `req_a[g]`, `req_b[g]` and g into the operand registers.
  - Move to MUL.
  - If no `req_valid` is set, stay in IDLE with `req_ready`=0.
- MUL:
  - Feed the latched operands to the multiplier.
  - Register the 8-bit product into `rsp_p` and g into `rsp_id`.
  - Set `rsp_valid`. Move to RSP.
- RSP:
  - Hold `rsp_valid`, `rsp_p` and `rsp_id` stable until `rsp_ready`=1.
  - On the handshake, clear `rsp_valid` and move to IDLE.
- Round robin:
  - Pointer `last` holds the index of the most recent grant; reset value NREQ-1.
  - The search starts at last+1 and wraps modulo NREQ. The first set `req_valid` bit wins.
  - `last` updates only on an accept.
- Arithmetic: product is unsigned and zero-extended, with no truncation. 15*15 = 225 = 8'hE1.
- `req_ready` is 0 for every requester in MUL and RSP. A requester keeps `req_valid` and its operands stable until its ready bit is seen.
- A requester that drops `req_valid` while not granted is simply skipped; this is not an error.
- Simultaneous requests: exactly one grant per accept cycle; the others wait.
- Out-of-range requester bits (index >= NREQ) do not exist; IDs are always < NREQ.

## Timing
- Accept in cycle T (IDLE, `req_ready[g]`=1), then MUL in T+1, then `rsp_valid`=1 from T+2.
- Accept-to-response latency is 2 cycles.
- With `rsp_ready` held high, the FSM is back in IDLE at T+3 and the next accept can occur in T+3.
- Peak throughput is 1 op per 3 cycles.
- Backpressure: each cycle of `rsp_ready`=0 in RSP adds one cycle. No operation is lost or duplicated.
- Reset values: state IDLE, `last`=NREQ-1, `rsp_valid`=0, `rsp_p`=0, `rsp_id`=0, `busy`=0, operand registers 0.
- `req_ready` is forced to 0 while `rst_n`=0.
- Reset mid-operation (MUL or RSP): the in-flight operation is discarded with no response, and all outputs return to reset values immediately.
- After reset release, the first grant goes to the lowest-index active requester.

## Configuration
- `MUL_SHARE_FIXED_PRIO_EN`:
  - Defined: the round-robin pointer is removed and grant is fixed priority, lowest index wins. `last` is not implemented.
  - Undefined (default): round robin as described above.
- Latency, handshake and FSM are identical in both builds.

## Test plan
- Single requester: requester 2 only, A=4'd7, B=4'd9.
  - Required: `req_ready`=4'b0100 for one cycle.
  - Two cycles later, `rsp_valid`=1, `rsp_p`=8'd63, `rsp_id`=2.
- Fairness: all four requesters valid continuously, each with A=i+1, B=4'd15, `rsp_ready`=1.
  - Required: responses in ID order 0,1,2,3,0,… with products 15,30,45,60.
  - Accept cycles 3 cycles apart.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid` rises.
  - Required: `rsp_p` and `rsp_id` stable and `req_ready`=0 throughout.
  - Exactly one response when `rsp_ready` rises.
- Corner operands: A=B=4'd15, then A=0 with B=4'd13.
  - Required: `rsp_p`=8'hE1, then 8'h00.
- Reset in MUL: assert `rst_n`=0 for one cycle one cycle after an accept.
  - Required: no `rsp_valid`, all outputs at reset values.
  - With requesters 1 and 3 valid afterwards, next grant goes to requester 1.
- Build with `MUL_SHARE_FIXED_PRIO_EN`: requesters 0 and 3 valid continuously.
  - Required: requester 0 is granted every time and requester 3 is never granted.
